instr_fetch_queue: RTL
======================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port IMemReq  output  1  fetch request valid to instruction memory.
REQ-006 SHALL have port IMemAddr  output  32  fetch request word address, bits[1:0] always 0.
REQ-007 SHALL have port IMemReady  input  1  memory accepts request this cycle.
REQ-008 SHALL have port IMemRvalid  input  1  in-order response valid.
REQ-009 SHALL have port IMemRdata  input  32  response instruction word.
REQ-010 SHALL have port RedirectF  input  1  branch/PC-write redirect (BranchTakenE | PCSrcW).
REQ-011 SHALL have port RedirectPC  input  32  new fetch address.
REQ-012 SHALL have port StallF  input  1  fetch stage holding; no dequeue.
REQ-013 SHALL have ports InstrF  output  32, PCF  output  32, InstrValidF  output  1  head instruction, its address, head valid.

Function
REQ-014 Request accepted when IMemReq & IMemReady; accepted request increments FetchAddr by 4, wrapping 32'hFFFFFFFC -> 32'h0.
REQ-015 IMemReq SHALL be high iff ~RedirectF and (count + inflight) < DEPTH, guaranteeing responses never overflow the queue.
REQ-016 inflight (width clog2(DEPTH+1)) SHALL increment on accept, decrement on IMemRvalid, unchanged when both occur.
REQ-017 A response with drop != 0 SHALL be discarded and drop decremented; otherwise {RespPC, IMemRdata} SHALL be pushed and RespPC += 4.
REQ-018 InstrValidF = (count != 0); head dequeued when InstrValidF & ~StallF & ~RedirectF.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and preserve order; pointers wrap modulo DEPTH.
REQ-020 On RedirectF: queue flushed (count=0), FetchAddr and RespPC set to {RedirectPC[31:2],2'b00}, drop set to inflight - IMemRvalid (already-issued requests discarded, including one responding that cycle).
REQ-021 RedirectF SHALL take priority over StallF, push and pop in the same cycle.
REQ-022 Redirect while drop != 0 SHALL set drop to total in-flight count, never to drop + inflight.
REQ-023 Latency without bypass: response in cycle N visible on InstrF/PCF with InstrValidF=1 in cycle N+1.
REQ-024 InstrF/PCF SHALL hold stable while InstrValidF & StallF.

Reset
REQ-025 On reset: FetchAddr=RespPC=RESET_PC, count=inflight=drop=0, pointers 0, InstrValidF=0, IMemReq=0, InstrF=PCF=0.
REQ-026 Reset mid-operation SHALL abandon all in-flight requests; instruction memory SHALL share the same reset so no stale responses arrive.
REQ-027 IMemReq SHALL first assert the cycle after reset deasserts, with IMemAddr=RESET_PC.

Configuration
REQ-028 Macro FETCH_QUEUE_BYPASS_EN: when defined, a non-dropped response arriving with count==0 and no redirect SHALL appear combinationally on InstrF/PCF with InstrValidF=1 that cycle; if ~StallF it is consumed and not pushed, otherwise pushed.
REQ-029 Without FETCH_QUEUE_BYPASS_EN, every response passes through the queue (REQ-023); no combinational path IMemRdata -> InstrF.

Verification
REQ-030 Reset release, IMemReady=1, 1-cycle memory, StallF=0 -> addresses 0,4,8,C issued back-to-back; InstrF/PCF stream in order, PCF 0,4,8,...
REQ-031 StallF=1 for 10 cycles -> exactly DEPTH=4 requests issued, count=4, IMemReq=0, InstrF held at PC 0; release -> one dequeue per cycle.
REQ-032 RedirectF with RedirectPC=32'h100 while 3 requests in flight -> next 3 responses dropped, next InstrF has PCF=32'h100.
REQ-033 RedirectPC=32'h103 -> IMemAddr=32'h100; FetchAddr=32'hFFFFFFFC accepted -> next IMemAddr=32'h0.
REQ-034 Response and RedirectF same cycle, then second redirect before drop reaches 0 -> only instructions at second redirect target ever reach InstrF.
REQ-035 With FETCH_QUEUE_BYPASS_EN, empty queue, response 32'hE3A00001 at cycle N, StallF=0 -> InstrF=32'hE3A00001, InstrValidF=1 in cycle N, count stays 0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues word fetches, absorbs in-order responses, drops stale ones after redirect.
// Optional FETCH_QUEUE_BYPASS_EN forwards a response straight to InstrF when the queue is empty.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic        IMemRvalid,
    input  logic [31:0] IMemRdata,
    input  logic        RedirectF,
    input  logic [31:0] RedirectPC,
    input  logic        StallF,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic        InstrValidF
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [31:0]   fetch_addr;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          started;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];

    logic [31:0]   redirect_base;
    logic [CW:0]   occupancy;
    logic          accept;
    logic          resp_keep;
    logic          head_valid;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          pop_head;

    assign redirect_base = RedirectPC & WORD_MASK;
    assign occupancy     = {1'b0, count} + {1'b0, inflight};

    // Counting in-flight requests against free slots means a response always has room.
    assign IMemReq  = started & ~RedirectF & (occupancy < DEPTH_C);
    assign IMemAddr = fetch_addr;
    assign accept   = IMemReq & IMemReady;

    assign resp_keep  = IMemRvalid & (drop == '0) & ~RedirectF;
    assign head_valid = (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass      = resp_keep & ~head_valid;
    assign InstrValidF = head_valid | bypass;
    assign InstrF      = bypass ? IMemRdata :
                         head_valid ? q_instr[rd_ptr] : '0;
    assign PCF         = bypass ? resp_pc :
                         head_valid ? q_pc[rd_ptr] : '0;
`else
    assign bypass      = 1'b0;
    assign InstrValidF = head_valid;
    assign InstrF      = head_valid ? q_instr[rd_ptr] : '0;
    assign PCF         = head_valid ? q_pc[rd_ptr] : '0;
`endif

    assign pop      = InstrValidF & ~StallF & ~RedirectF;
    assign pop_head = pop & head_valid;
    // A bypassed word consumed this cycle never enters storage.
    assign push     = resp_keep & ~(bypass & ~StallF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started    <= 1'b0;
            fetch_addr <= RESET_PC & WORD_MASK;
            resp_pc    <= RESET_PC & WORD_MASK;
            count      <= '0;
            inflight   <= '0;
            drop       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            started  <= 1'b1;
            inflight <= inflight + CW'(accept) - CW'(IMemRvalid);
            if (RedirectF) begin
                // Every request still outstanding after this edge is stale.
                fetch_addr <= redirect_base;
                resp_pc    <= redirect_base;
                count      <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                drop       <= inflight - CW'(IMemRvalid);
            end else begin
                if (accept) begin
                    fetch_addr <= fetch_addr + 32'd4;
                end
                if (IMemRvalid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop_head) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop_head);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= IMemRdata;
            q_pc[wr_ptr]    <= resp_pc;
        end
    end

endmodule
